usb_tx_packet: RTL
==================

Name: usb_tx_packet

Overview:
- Low-speed USB packet framer sitting directly upstream of the serial sender.
- On a `start` from the SIE, it builds a handshake packet (PID only) or a data packet (PID, payload, CRC16).
- Bytes are handed to the sender one per `tx_ready` pulse; `tx_valid` is held high for the whole packet and dropped to request EOP.
- Payload is read from the SIE endpoint buffer through a 1-cycle-latency read port.

Parameters:
- MAX_LEN, 8, maximum payload bytes (low-speed limit).
- AW, $clog2(MAX_LEN), width of the buffer read address.
- IPG_CLKS, 64, clocks of line-idle hold-off after `tx_valid` falls (used only with the optional feature).

Ports:
- clk  in  1  system clock, 24 MHz.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to send; sampled only in IDLE.
- pid  in  4  PID nibble; pid[1:0]=2'b11 means DATA0/DATA1, 2'b10 means ACK/NAK/STALL.
- len  in  $clog2(MAX_LEN+1)  payload byte count; ignored for handshakes.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  AW  buffer read address.
- rd_data  in  8  buffer byte; valid the cycle after rd_en.
- tx_data  out  8  byte offered to the sender.
- tx_valid  out  1  rise starts SYNC; high while sending; fall requests EOP.
- tx_ready  in  1  one-cycle pulse when the sender captures tx_data.
- busy  out  1  packet in progress.
- done  out  1  one-cycle pulse at packet end.
- err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (asynchronous): FSM goes to IDLE. tx_valid, tx_data, rd_en, rd_addr, busy, done and err all go to 0; crc=16'hFFFF. A reset mid-packet drops tx_valid immediately.
- FSM states: IDLE, PID, DATA, CRC_LO, CRC_HI, LAST, HOLD (HOLD exists only with the option).
- IDLE:
  - start with pid[1]=0, or with a data PID and len>MAX_LEN → err=1 for one cycle, stay in IDLE.
  - start that is legal → latch pid and len; next cycle tx_valid=1, tx_data={~pid,pid}, busy=1, crc=16'hFFFF, go to PID.
  - If the PID is a data PID and len>0, also assert rd_en with rd_addr=0 in that same next cycle.
- PID, on tx_ready (the sender has captured the PID):
  - handshake → LAST.
  - data, len=0 → tx_data=~crc[7:0], go to CRC_LO.
  - data, len>0 → tx_data=rd_data (held from the prefetch), crc=crc16(crc,rd_data), idx=1, go to DATA; if len>1, issue rd_en with rd_addr=1.
- DATA, on tx_ready:
  - idx<len → tx_data=buffered byte idx, update crc, idx+1, prefetch idx+1 if it is <len.
  - idx==len → tx_data=~crc[7:0], go to CRC_LO.
- CRC_LO, on tx_ready → tx_data=~crc[15:8], go to CRC_HI.
- CRC_HI, on tx_ready → go to LAST.
- LAST, on tx_ready → the cycle after, tx_valid=0, done=1 and busy=0 (or go to HOLD with the option), return to IDLE.
- tx_data changes only in the cycle after a tx_ready pulse, and never while tx_valid=0 mid-packet.
- CRC16 rule:
  - Reflected form, polynomial 0x8005 (0xA001 reflected), init 16'hFFFF, data bits processed LSB first.
  - One full byte per cycle (combinational 8-step unroll).
  - Transmitted value is the complemented register, low byte first.
- Read buffering: the prefetched byte is registered on the cycle after rd_en, so rd_data may change afterwards. At most one read is outstanding; tx_ready pulses are ≥128 clocks apart.
- tx_ready seen outside PID/DATA/CRC_LO/CRC_HI/LAST is ignored.
- start while busy is ignored; no err is raised.
- Byte count check: the sender sees exactly N tx_ready pulses with tx_valid=1, where N = (#bytes + 1). The extra pulse is the one that triggers EOP.

Optional Feature:
- Macro USB_TX_PACKET_IPG_EN.
- Defined: after tx_valid falls, the FSM enters HOLD with busy=1. A counter runs for IPG_CLKS clocks, then done=1 and busy=0. This covers the EOP and turnaround time; start is ignored in HOLD.
- Undefined: no HOLD state and IPG_CLKS is unused. done and busy=0 occur in the cycle after tx_valid falls.

Test Plan:
- Stub sender pulses tx_ready every 128 clocks. pid=4'b0010 (ACK) → bytes [0xD2]. tx_valid falls 1 cycle after the 2nd tx_ready, done pulses once, rd_en never asserted.
- pid=4'b0011 (DATA0), len=0 → bytes [0xC3,0x00,0x00], then tx_valid falls after the 4th tx_ready.
- MAX_LEN=16 override, pid=4'b1011 (DATA1), len=9, buffer "123456789" → bytes [0x4B,0x31..0x39,0xC8,0xB4]. rd_addr sequence 0..8, one read per byte.
- start with pid=4'b0001, and separately DATA0 with len=MAX_LEN+1 → err single pulse each time; tx_valid stays 0, busy stays 0.
- Assert reset mid-DATA of an 8-byte packet → tx_valid=0 same cycle. After release, a new ACK start produces a clean [0xD2] packet with crc reinitialised.
- With USB_TX_PACKET_IPG_EN: start pulsed during HOLD is ignored; done arrives exactly IPG_CLKS cycles after tx_valid falls.

Source files
------------

// File: rtl/usb_tx_packet_if.sv
// Framer-side bundle: SIE start request, endpoint buffer read port, serial sender handshake and status.
// master = packet framer, slave = SIE / buffer / sender side.
interface usb_tx_packet_if #(
   parameter int unsigned MAX_LEN = 8
);
   localparam int unsigned AW = $clog2(MAX_LEN);
   localparam int unsigned LW = $clog2(MAX_LEN + 1);

   logic          start;
   logic [3:0]    pid;
   logic [LW-1:0] len;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          busy;
   logic          done;
   logic          err;

   modport master (
      input  start, pid, len, rd_data, tx_ready,
      output rd_en, rd_addr, tx_data, tx_valid, busy, done, err
   );

   modport slave (
      output start, pid, len, rd_data, tx_ready,
      input  rd_en, rd_addr, tx_data, tx_valid, busy, done, err
   );
endinterface

// File: rtl/usb_tx_packet.sv
// Low-speed USB packet framer: PID, optional payload and CRC16, handed byte-wise to the sender.
// Define USB_TX_PACKET_IPG_EN to add a post-EOP hold-off state of IPG_CLKS clocks.
module usb_tx_packet #(
   parameter int unsigned MAX_LEN  = 8,
   parameter int unsigned AW       = $clog2(MAX_LEN),
   parameter int unsigned IPG_CLKS = 64
) (
   input logic             clk_i,
   input logic             rst_i,
   usb_tx_packet_if.master bus
);
   localparam int unsigned   LW      = $clog2(MAX_LEN + 1);
   localparam logic [LW-1:0] MaxLenL = LW'(MAX_LEN);

`ifdef USB_TX_PACKET_IPG_EN
   typedef enum logic [2:0] {StIdle, StPid, StData, StCrcLo, StCrcHi, StLast, StHold} state_e;
   localparam int unsigned CW = $clog2(IPG_CLKS + 1);
   logic [CW-1:0] ipg_q;
`else
   typedef enum logic [2:0] {StIdle, StPid, StData, StCrcLo, StCrcHi, StLast} state_e;
`endif

   state_e        state_q;
   logic          data_pid_q;
   logic [LW-1:0] len_q;
   logic [LW-1:0] idx_q;
   logic [15:0]   crc_q;
   logic [7:0]    buf_q;
   logic [7:0]    tx_data_q;
   logic          rd_pend_q;
   logic          rd_en_q;
   logic [AW-1:0] rd_addr_q;
   logic          tx_valid_q;
   logic          busy_q;
   logic          done_q;
   logic          err_q;

   logic [15:0]   crc_d;
   logic [LW-1:0] idx_d;
   logic          start_bad;

   // Reflected CRC16 (0xA001), one byte per call, LSB first.
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
      logic [15:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
         else             c = c >> 1;
      end
      return c;
   endfunction

   always_comb begin
      crc_d     = crc16_byte(crc_q, buf_q);
      idx_d     = idx_q + LW'(1);
      start_bad = !bus.pid[1] || (bus.pid[0] && (bus.len > MaxLenL));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         data_pid_q <= 1'b0;
         len_q      <= '0;
         idx_q      <= '0;
         crc_q      <= 16'hFFFF;
         buf_q      <= 8'h00;
         tx_data_q  <= 8'h00;
         rd_pend_q  <= 1'b0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef USB_TX_PACKET_IPG_EN
         ipg_q      <= '0;
`endif
      end else begin
         rd_en_q   <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         // Buffer data is only valid the cycle after the strobe; capture it then.
         rd_pend_q <= rd_en_q;
         if (rd_pend_q) buf_q <= bus.rd_data;

         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  if (start_bad) begin
                     err_q <= 1'b1;
                  end else begin
                     data_pid_q <= bus.pid[0];
                     len_q      <= bus.len;
                     tx_valid_q <= 1'b1;
                     tx_data_q  <= {~bus.pid, bus.pid};
                     busy_q     <= 1'b1;
                     crc_q      <= 16'hFFFF;
                     state_q    <= StPid;
                     if (bus.pid[0] && (bus.len != '0)) begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                     end
                  end
               end
            end
            StPid: begin
               if (bus.tx_ready) begin
                  if (!data_pid_q) begin
                     state_q <= StLast;
                  end else if (len_q == '0) begin
                     tx_data_q <= ~crc_q[7:0];
                     state_q   <= StCrcLo;
                  end else begin
                     tx_data_q <= buf_q;
                     crc_q     <= crc_d;
                     idx_q     <= LW'(1);
                     state_q   <= StData;
                     if (len_q > LW'(1)) begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= AW'(1);
                     end
                  end
               end
            end
            StData: begin
               if (bus.tx_ready) begin
                  if (idx_q < len_q) begin
                     tx_data_q <= buf_q;
                     crc_q     <= crc_d;
                     idx_q     <= idx_d;
                     if (idx_d < len_q) begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= AW'(idx_d);
                     end
                  end else begin
                     tx_data_q <= ~crc_q[7:0];
                     state_q   <= StCrcLo;
                  end
               end
            end
            StCrcLo: begin
               if (bus.tx_ready) begin
                  tx_data_q <= ~crc_q[15:8];
                  state_q   <= StCrcHi;
               end
            end
            StCrcHi: begin
               if (bus.tx_ready) state_q <= StLast;
            end
            StLast: begin
               // The extra sender pulse after the final byte requests EOP.
               if (bus.tx_ready) begin
                  tx_valid_q <= 1'b0;
`ifdef USB_TX_PACKET_IPG_EN
                  ipg_q   <= '0;
                  state_q <= StHold;
`else
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
`endif
               end
            end
`ifdef USB_TX_PACKET_IPG_EN
            StHold: begin
               if (ipg_q == CW'(IPG_CLKS - 1)) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  ipg_q <= ipg_q + CW'(1);
               end
            end
`endif
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.rd_en    = rd_en_q;
   assign bus.rd_addr  = rd_addr_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.tx_valid = tx_valid_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
endmodule
